// File: rtl/hsi_pkg.sv
// Shared constants, sector encoding and helper functions for the HSI-to-RGB path.
package hsi_pkg;

    localparam int HUE_MAX    = 360;
    localparam int SECTOR_DEG = 120;
    localparam int RATIO_W    = 11;
    localparam int PIX_W      = 8;
    localparam int HUE_W      = 9;
    localparam int LAT        = 4;

    localparam int HP_W      = 7;
    localparam int SQ_W      = 9;
    localparam int PROD_W    = 17;
    localparam int MUL_W     = 29;
    localparam int ACC_W     = 12;
    localparam int ROM_DEPTH = 128;
    localparam int HALF_SEC  = 60;

    localparam real DEG2RAD = 3.14159265358979323846 / 180.0;

    typedef enum logic [1:0] {
        SEC_RG = 2'd0,
        SEC_GB = 2'd1,
        SEC_BR = 2'd2
    } sector_e;

    // Table generator: round(256*cos(h)/cos(60-h)), elaborated once per ROM word.
    function automatic logic signed [RATIO_W-1:0] hue_ratio_entry(input int hp);
        real num_v;
        real den_v;
        real q_v;
        int  r_v;
        if (hp >= SECTOR_DEG) begin
            r_v = 0;
        end else begin
            num_v = $cos(real'(hp) * DEG2RAD);
            den_v = $cos(real'(HALF_SEC - hp) * DEG2RAD);
            q_v   = 256.0 * num_v / den_v;
            if (q_v >= 0.0) begin
                r_v = $rtoi(q_v + 0.5);
            end else begin
                r_v = -$rtoi(0.5 - q_v);
            end
        end
        return RATIO_W'(r_v);
    endfunction

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v < 12'sd0) begin
            r = 8'd0;
        end else if (v > 12'sd255) begin
            r = 8'd255;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/hsi_ratio_rom.sv
// Hue-ratio lookup: 120 signed Q2.8 words (padded to 128), registered read.
module hsi_ratio_rom
    import hsi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en,
    input  logic [HP_W-1:0]           addr,
    output logic signed [RATIO_W-1:0] ratio
);

    logic signed [RATIO_W-1:0] rom_s [ROM_DEPTH];

    // Words beyond the last hue offset read as zero so every address is defined.
    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        assign rom_s[k] = hue_ratio_entry(k);
    end

    // Registered read; holds its word while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ratio <= '0;
        end else if (rd_en) begin
            ratio <= rom_s[addr];
        end
    end

endmodule

// File: rtl/hsi2rgb_pipe.sv
// HSI to 8-bit RGB converter: four-stage divider-free pipeline whose stages
// all advance together, or all hold when the downstream side stalls.
module hsi2rgb_pipe
    import hsi_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iDVAL,
    output logic             oREADY,
    input  logic             iSOF,
    input  logic [HUE_W-1:0] iH,
    input  logic [PIX_W-1:0] iS,
    input  logic [PIX_W-1:0] iI,
    output logic             oDVAL,
    input  logic             iREADY,
    output logic             oSOF,
    output logic [PIX_W-1:0] oR,
    output logic [PIX_W-1:0] oG,
    output logic [PIX_W-1:0] oB
);

    logic           en_s;
    logic [LAT-1:0] vld_r;
    logic [LAT-1:0] sof_r;

    logic [HUE_W-1:0] h_wrap_s;
    sector_e          sec_s;
    logic [HP_W-1:0]  hp_s;
    logic [SQ_W-1:0]  sq_s;

    logic [PIX_W-1:0] i1_r;
    sector_e          sec1_r;
    logic [HP_W-1:0]  hp1_r;
    logic [SQ_W-1:0]  sq1_r;

    logic [PROD_W-1:0]         p_s;
    logic [SQ_W-1:0]           lo_s;
    logic [PIX_W-1:0]          i2_r;
    sector_e                   sec2_r;
    logic [PROD_W-1:0]         p2_r;
    logic [SQ_W-1:0]           lo2_r;
    logic signed [RATIO_W-1:0] ratio2_s;

    logic signed [MUL_W-1:0] prod_s;
    logic signed [ACC_W-1:0] hi_s;
    logic signed [ACC_W-1:0] rest_s;
    sector_e                 sec3_r;
    logic signed [ACC_W-1:0] hi3_r;
    logic signed [ACC_W-1:0] rest3_r;
    logic signed [ACC_W-1:0] lo3_r;

    logic [PIX_W-1:0] hi_c_s;
    logic [PIX_W-1:0] rest_c_s;
    logic [PIX_W-1:0] lo_c_s;
    logic [PIX_W-1:0] r_s;
    logic [PIX_W-1:0] g_s;
    logic [PIX_W-1:0] b_s;

    assign en_s   = !vld_r[LAT-1] || iREADY;
    assign oREADY = en_s;
    assign oDVAL  = vld_r[LAT-1];
    assign oSOF   = sof_r[LAT-1];

    // Hue wrap, sector split and saturation rescale so that S=255 acts as 1.0.
    always_comb begin
        h_wrap_s = iH;
        sec_s    = SEC_RG;
        hp_s     = '0;
        if (iH >= HUE_W'(HUE_MAX)) begin
            h_wrap_s = '0;
        end else begin
            h_wrap_s = iH;
        end
        if (h_wrap_s < HUE_W'(SECTOR_DEG)) begin
            sec_s = SEC_RG;
            hp_s  = HP_W'(h_wrap_s);
        end else if (h_wrap_s < HUE_W'(2 * SECTOR_DEG)) begin
            sec_s = SEC_GB;
            hp_s  = HP_W'(h_wrap_s - HUE_W'(SECTOR_DEG));
        end else begin
            sec_s = SEC_BR;
            hp_s  = HP_W'(h_wrap_s - HUE_W'(2 * SECTOR_DEG));
        end
        sq_s = {1'b0, iS} + {8'd0, iS[PIX_W-1]};
    end

    // Stage valids and frame-start flag travel as one shift chain.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            vld_r <= '0;
            sof_r <= '0;
        end else if (en_s) begin
            vld_r <= {vld_r[LAT-2:0], iDVAL};
            sof_r <= {sof_r[LAT-2:0], iDVAL && iSOF};
        end
    end

    // Stage 1 register: decoded hue and scaled saturation.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            i1_r   <= '0;
            sec1_r <= SEC_RG;
            hp1_r  <= '0;
            sq1_r  <= '0;
        end else if (en_s) begin
            i1_r   <= iI;
            sec1_r <= sec_s;
            hp1_r  <= hp_s;
            sq1_r  <= sq_s;
        end
    end

    hsi_ratio_rom u_ratio_rom (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .rd_en (en_s),
        .addr  (hp1_r),
        .ratio (ratio2_s)
    );

    assign p_s  = PROD_W'(i1_r) * PROD_W'(sq1_r);
    assign lo_s = {1'b0, i1_r} - p_s[PROD_W-1:PIX_W];

    // Stage 2 register: I*S product and the minimum channel; ratio arrives from the ROM.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            i2_r   <= '0;
            sec2_r <= SEC_RG;
            p2_r   <= '0;
            lo2_r  <= '0;
        end else if (en_s) begin
            i2_r   <= i1_r;
            sec2_r <= sec1_r;
            p2_r   <= p_s;
            lo2_r  <= lo_s;
        end
    end

    // Floor shift keeps negative ratios rounding toward minus infinity.
    assign prod_s = MUL_W'($signed({1'b0, p2_r})) * MUL_W'(ratio2_s);
    assign hi_s   = ACC_W'(i2_r) + ACC_W'(prod_s >>> 5'd16);
    assign rest_s = ACC_W'({i2_r, 1'b0}) + ACC_W'(i2_r) - hi_s - ACC_W'(lo2_r);

    // Stage 3 register: unclamped lead, trailing and minimum channel values.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sec3_r  <= SEC_RG;
            hi3_r   <= '0;
            rest3_r <= '0;
            lo3_r   <= '0;
        end else if (en_s) begin
            sec3_r  <= sec2_r;
            hi3_r   <= hi_s;
            rest3_r <= rest_s;
            lo3_r   <= ACC_W'(lo2_r);
        end
    end

    // Saturate to 8 bits and rotate channels according to the hue sector.
    always_comb begin
        hi_c_s   = clamp_pix(hi3_r);
        rest_c_s = clamp_pix(rest3_r);
        lo_c_s   = clamp_pix(lo3_r);
        r_s      = 8'd0;
        g_s      = 8'd0;
        b_s      = 8'd0;
        case (sec3_r)
            SEC_RG: begin
                r_s = hi_c_s;
                g_s = rest_c_s;
                b_s = lo_c_s;
            end
            SEC_GB: begin
                r_s = lo_c_s;
                g_s = hi_c_s;
                b_s = rest_c_s;
            end
            SEC_BR: begin
                r_s = rest_c_s;
                g_s = lo_c_s;
                b_s = hi_c_s;
            end
            default: begin
                r_s = 8'd0;
                g_s = 8'd0;
                b_s = 8'd0;
            end
        endcase
    end

    // Stage 4 register: the visible RGB outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oR <= '0;
            oG <= '0;
            oB <= '0;
        end else if (en_s) begin
            oR <= r_s;
            oG <= g_s;
            oB <= b_s;
        end
    end

endmodule

// File: tb/tb_hsi2rgb_pipe.sv
// Self-checking bench for hsi2rgb_pipe: directed colour points, reset, stall
// and throughput scenarios plus random traffic against a behavioural model.
module tb_hsi2rgb_pipe;

    localparam real PI = 3.14159265358979323846;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iDVAL  = 1'b0;
    logic       iSOF   = 1'b0;
    logic       iREADY = 1'b1;
    logic [8:0] iH     = 9'd0;
    logic [7:0] iS     = 8'd0;
    logic [7:0] iI     = 8'd0;
    logic       oREADY;
    logic       oDVAL;
    logic       oSOF;
    logic [7:0] oR;
    logic [7:0] oG;
    logic [7:0] oB;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int en_cnt  = 0;
    int rdy_mode = 0;

    typedef struct {
        int h;
        int s;
        int i;
        bit sof;
        int en_at;
    } pix_t;

    pix_t        exp_q[$];
    bit          hold_v = 1'b0;
    logic [24:0] held_v;

    hsi2rgb_pipe dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iDVAL  (iDVAL),
        .oREADY (oREADY),
        .iSOF   (iSOF),
        .iH     (iH),
        .iS     (iS),
        .iI     (iI),
        .oDVAL  (oDVAL),
        .iREADY (iREADY),
        .oSOF   (oSOF),
        .oR     (oR),
        .oG     (oG),
        .oB     (oB)
    );

    always #5 iCLK = ~iCLK;

    // Reference: the hue-ratio table value straight from the trigonometric definition.
    function automatic int ratio_ref(input int hp);
        real q;
        q = 256.0 * $cos(real'(hp) * PI / 180.0) / $cos(real'(60 - hp) * PI / 180.0);
        if (q >= 0.0) return $rtoi(q + 0.5);
        return -$rtoi(0.5 - q);
    endfunction

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] rgb_ref(input int h, input int s, input int i);
        int hh, sec, hp, sq, p, lo, hi, rest, a, b, c;
        hh   = (h >= 360) ? 0 : h;
        sec  = hh / 120;
        hp   = hh - 120 * sec;
        sq   = s + s / 128;
        p    = i * sq;
        lo   = i - p / 256;
        hi   = i + ((p * ratio_ref(hp)) >>> 16);
        rest = 3 * i - hi - lo;
        a    = clamp8(hi);
        b    = clamp8(rest);
        c    = clamp8(lo);
        case (sec)
            0:       return {a[7:0], b[7:0], c[7:0]};
            1:       return {c[7:0], a[7:0], b[7:0]};
            default: return {b[7:0], c[7:0], a[7:0]};
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    // iREADY driver: steady high, a fixed 1,0,0,1 pattern, or random.
    initial begin
        int ph;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph  = 0;
        forever begin
            @(posedge iCLK);
            #1;
            case (rdy_mode)
                1: begin
                    iREADY = pat[ph % 4];
                    ph++;
                end
                2:       iREADY = 1'($urandom_range(0, 1));
                default: iREADY = 1'b1;
            endcase
        end
    end

    // Scoreboard and handshake checks, sampled mid-cycle.
    always @(negedge iCLK) begin
        if (iRST_N !== 1'b1) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            n_cmp++;
            if (oREADY !== (!oDVAL || iREADY)) begin
                n_fail++;
                $display("FAIL ready_rule: oREADY=%b required %b", oREADY, (!oDVAL || iREADY));
            end
            if (hold_v) begin
                n_cmp++;
                if (oDVAL !== 1'b1 || {oSOF, oR, oG, oB} !== held_v) begin
                    n_fail++;
                    $display("FAIL stall_hold: got dval=%b %h required dval=1 %h", oDVAL, {oSOF, oR, oG, oB}, held_v);
                end
            end
            if (oDVAL === 1'b1 && iREADY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pixel %h required none", {oSOF, oR, oG, oB});
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    n_out++;
                    n_cmp++;
                    if ({oSOF, oR, oG, oB} !== {e.sof, rgb_ref(e.h, e.s, e.i)}) begin
                        n_fail++;
                        $display("FAIL pixel H=%0d S=%0d I=%0d: got %h required %h", e.h, e.s, e.i,
                                 {oSOF, oR, oG, oB}, {e.sof, rgb_ref(e.h, e.s, e.i)});
                    end
                    n_cmp++;
                    if (en_cnt - e.en_at != 4) begin
                        n_fail++;
                        $display("FAIL latency: got %0d required 4", en_cnt - e.en_at);
                    end
                end
            end
            hold_v = (oDVAL === 1'b1) && (iREADY !== 1'b1);
            held_v = {oSOF, oR, oG, oB};
            if (iDVAL === 1'b1 && oREADY === 1'b1) begin
                pix_t n;
                n.h     = int'(iH);
                n.s     = int'(iS);
                n.i     = int'(iI);
                n.sof   = iSOF;
                n.en_at = en_cnt;
                exp_q.push_back(n);
            end
            if (oREADY === 1'b1) en_cnt++;
        end
    end

    task automatic rand_pix();
        iH = 9'($urandom_range(0, 511));
        case ($urandom_range(0, 7))
            0:       iS = 8'd0;
            1:       iS = 8'd255;
            default: iS = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 7))
            0:       iI = 8'd0;
            1:       iI = 8'd255;
            default: iI = 8'($urandom_range(0, 255));
        endcase
    endtask

    task automatic directed(input int h, input int s, input int i, input logic [23:0] want, input string nm);
        bit seen;
        cmp({nm, "_model"}, {8'd0, rgb_ref(h, s, i)}, {8'd0, want});
        @(posedge iCLK);
        #1;
        iH = 9'(h); iS = 8'(s); iI = 8'(i); iSOF = 1'b0; iDVAL = 1'b1;
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge iCLK);
            if (oDVAL === 1'b1) begin
                seen = 1'b1;
                cmp(nm, {8'd0, oR, oG, oB}, {8'd0, want});
            end
        end
        if (!seen) cmp({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Caller is positioned just after a rising edge; returns likewise.
    task automatic send(input bit sof);
        bit ok;
        rand_pix();
        iSOF  = sof;
        iDVAL = 1'b1;
        ok    = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge iCLK);
            if (oREADY === 1'b1) ok = 1'b1;
        end
        if (!ok) cmp("send_timeout", 32'd0, 32'd1);
        @(posedge iCLK);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge iCLK);
        cmp({nm, "_drain"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int base;
        int dv_hits;

        cmp("ratio_0",   ratio_ref(0),   512);
        cmp("ratio_60",  ratio_ref(60),  128);
        cmp("ratio_119", ratio_ref(119), -241);

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        cmp("reset_state", {7'd0, oDVAL, oSOF, oR, oG, oB}, 32'd0);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        @(negedge iCLK);
        cmp("ready_after_reset", {31'd0, oREADY}, 32'd1);

        directed(0,   255, 85,  24'hFF0000, "red");
        directed(200, 0,   200, 24'hC8C8C8, "grey");
        directed(180, 255, 100, 24'h009696, "cyan");
        directed(360, 255, 85,  24'hFF0000, "wrap");
        directed(0,   255, 200, 24'hFF0000, "clamp");
        directed(240, 255, 85,  24'h0000FF, "hue_240");
        directed(120, 255, 85,  24'h00FF00, "hue_120");
        directed(77,  200, 0,   24'h000000, "black");

        // Reset with three pixels in flight.
        @(posedge iCLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            rand_pix();
            iDVAL = 1'b1;
            iSOF  = 1'b0;
            @(posedge iCLK);
            #1;
        end
        iDVAL  = 1'b0;
        iRST_N = 1'b0;
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        @(negedge iCLK);
        cmp("midreset_out", {7'd0, oDVAL, oSOF, oR, oG, oB}, 32'd0);
        cmp("midreset_ready", {31'd0, oREADY}, 32'd1);
        dv_hits = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iCLK);
            if (oDVAL === 1'b1) dv_hits++;
        end
        cmp("midreset_stale", dv_hits, 32'd0);

        // Backpressure: ten pixels, first flagged as start of frame.
        base     = n_out;
        rdy_mode = 1;
        @(posedge iCLK);
        #1;
        for (int k = 0; k < 10; k++) send(k == 0);
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        drain("bp");
        cmp("bp_count", n_out - base, 32'd10);

        // Random traffic, including SOF on cycles that are not accepted.
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            @(posedge iCLK);
            #1;
            rand_pix();
            iDVAL = ($urandom_range(0, 9) < 7);
            iSOF  = 1'($urandom_range(0, 1));
        end
        @(posedge iCLK);
        #1;
        iDVAL    = 1'b0;
        iSOF     = 1'b0;
        rdy_mode = 0;
        drain("rand");
        repeat (3) @(posedge iCLK);

        // Throughput: 100 back-to-back pixels with iREADY held high.
        base = n_out;
        for (int c = 0; c < 106; c++) begin
            @(posedge iCLK);
            #1;
            if (c < 100) begin
                rand_pix();
                iDVAL = 1'b1;
                iSOF  = (c == 0);
            end else begin
                iDVAL = 1'b0;
                iSOF  = 1'b0;
            end
            @(negedge iCLK);
            cmp($sformatf("thru_dval_c%0d", c), {31'd0, oDVAL}, {31'd0, (c >= 4 && c <= 103)});
        end
        drain("thru");
        cmp("thru_count", n_out - base, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
